dwt_haar_mac: RTL

Pipelined Haar lifting responder for the 2D DWT datapath. It accepts pixel pairs and pointer tags issued by the memory/control sequencer and computes one approximation and one detail coefficient per pair. It returns the coefficients with the original tags, delayed to match, so the sequencer can form write addresses. It also tracks row/column passes and decomposition levels, flags out-of-sequence input, and signals pass and transform completion.

---
 rtl/dwt_haar_mac_if.sv | 34 +++
 rtl/dwt_haar_mac.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dwt_haar_mac_if.sv
// Sequencer <-> Haar MAC bus: pixel-pair request side plus coefficient/status return side.
interface dwt_haar_mac_if #(
    parameter int WIDTH = 256
);
    localparam int PW = $clog2(WIDTH);

    logic [15:0]   i_mac;
    logic          i_mac_valid;
    logic          i_mac_mode;
    logic [PW-1:0] i_mac_row_column_pointer;
    logic [PW-1:0] i_mac_pixel_pointer;

    logic [15:0]   o_mac;
    logic          o_mac_valid;
    logic          o_mac_mode;
    logic [PW-1:0] o_mac_row_column_pointer;
    logic [PW-1:0] o_mac_pixel_pointer;
    logic          o_pass_done;
    logic [2:0]    o_level;
    logic          o_all_done;
    logic          o_seq_err;

    modport master (
        output i_mac, i_mac_valid, i_mac_mode, i_mac_row_column_pointer, i_mac_pixel_pointer,
        input  o_mac, o_mac_valid, o_mac_mode, o_mac_row_column_pointer, o_mac_pixel_pointer,
        input  o_pass_done, o_level, o_all_done, o_seq_err
    );

    modport slave (
        input  i_mac, i_mac_valid, i_mac_mode, i_mac_row_column_pointer, i_mac_pixel_pointer,
        output o_mac, o_mac_valid, o_mac_mode, o_mac_row_column_pointer, o_mac_pixel_pointer,
        output o_pass_done, o_level, o_all_done, o_seq_err
    );
endinterface

// File: rtl/dwt_haar_mac.sv
// 3-stage Haar lifting responder with row/column pass sequencing and level tracking.
// Define DWT_MAC_ROUND_EN for rounded coefficients with detail saturation; default truncates.
module dwt_haar_mac #(
    parameter int HEIGHT              = 256,
    parameter int WIDTH               = 256,
    parameter int DECOMPOSITION_LEVEL = 1
) (
    input logic           clk,
    input logic           rst,
    dwt_haar_mac_if.slave bus
);
    localparam int PW     = $clog2(WIDTH);
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;

    typedef enum logic [1:0] {ST_ROW, ST_COL, ST_DONE} state_t;

`ifdef DWT_MAC_ROUND_EN
    function automatic logic [COEF_W-1:0] f_approx(input logic [DATA_W:0] sum);
        return COEF_W'(({1'b0, sum} + 10'd1) >> 1);
    endfunction

    function automatic logic [COEF_W-1:0] f_detail(input logic signed [DATA_W+1:0] diff);
        logic signed [DATA_W+2:0] t;
        t = ($signed({diff[DATA_W+1], diff}) + 11'sd1) >>> 1;
        t = t + 11'sd128;
        return (t > 11'sd255) ? {COEF_W{1'b1}} : COEF_W'(t);
    endfunction
`else
    function automatic logic [COEF_W-1:0] f_approx(input logic [DATA_W:0] sum);
        return COEF_W'(sum >> 1);
    endfunction

    function automatic logic [COEF_W-1:0] f_detail(input logic signed [DATA_W+1:0] diff);
        return COEF_W'((diff >>> 1) + 10'sd128);
    endfunction
`endif

    state_t          r_state, w_next_state;
    logic [2:0]      r_div_sh;
    logic [2:0]      r_lvl_in;
    logic [PW-1:0]   r_exp_pix, r_exp_rc;
    logic            r_seq_err;

    logic            w_exp_mode, w_active;
    logic [31:0]     w_len, w_lines;
    logic            w_line_end, w_pass_end, w_in_err;
    logic [2:0]      w_lvl_next;

    assign w_lvl_next = r_lvl_in + 3'd1;
    assign w_line_end = ({{(32-PW){1'b0}}, bus.i_mac_pixel_pointer} == (w_len - 32'd2));
    assign w_pass_end = w_active && w_line_end &&
                        ({{(32-PW){1'b0}}, bus.i_mac_row_column_pointer} == (w_lines - 32'd1));
    assign w_in_err   = bus.i_mac_valid &&
                        (!w_active || (bus.i_mac_mode != w_exp_mode) ||
                         (bus.i_mac_pixel_pointer != r_exp_pix) ||
                         (bus.i_mac_row_column_pointer != r_exp_rc));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_ROW;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (bus.i_mac_valid && w_pass_end) begin
            case (r_state)
                ST_ROW:  w_next_state = ST_COL;
                ST_COL:  w_next_state = (w_lvl_next == 3'(DECOMPOSITION_LEVEL)) ? ST_DONE : ST_ROW;
                default: w_next_state = r_state;
            endcase
        end
    end

    // Line geometry shrinks by div (a power of two) once per completed level.
    always_comb begin
        w_exp_mode = 1'b0;
        w_active   = 1'b1;
        w_len      = 32'(WIDTH) >> r_div_sh;
        w_lines    = 32'(HEIGHT) >> r_div_sh;
        case (r_state)
            ST_COL: begin
                w_exp_mode = 1'b1;
                w_len      = 32'(HEIGHT) >> r_div_sh;
                w_lines    = 32'(WIDTH) >> r_div_sh;
            end
            ST_DONE: w_active = 1'b0;
            default: ;
        endcase
    end

    // Expected counters follow the received pointers so one slip is flagged only once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exp_pix <= '0;
            r_exp_rc  <= '0;
            r_div_sh  <= '0;
            r_lvl_in  <= '0;
            r_seq_err <= 1'b0;
        end else begin
            if (w_in_err) r_seq_err <= 1'b1;
            if (bus.i_mac_valid && w_active) begin
                if (w_pass_end) begin
                    r_exp_pix <= '0;
                    r_exp_rc  <= '0;
                    if (r_state == ST_COL) begin
                        r_div_sh <= r_div_sh + 3'd1;
                        r_lvl_in <= w_lvl_next;
                    end
                end else if (w_line_end) begin
                    r_exp_pix <= '0;
                    r_exp_rc  <= bus.i_mac_row_column_pointer + PW'(1);
                end else begin
                    r_exp_pix <= bus.i_mac_pixel_pointer + PW'(2);
                    r_exp_rc  <= bus.i_mac_row_column_pointer;
                end
            end
        end
    end

    // S1: capture pair and tags
    logic                    r_vld_p0, r_mode_p0, r_last_p0, r_fin_p0;
    logic [PW-1:0]           r_rc_p0, r_pix_p0;
    logic [DATA_W-1:0]       r_a_p0, r_b_p0;
    // S2: sum / difference
    logic                    r_vld_p1, r_mode_p1, r_last_p1, r_fin_p1;
    logic [PW-1:0]           r_rc_p1, r_pix_p1;
    logic [DATA_W:0]         r_sum_p1;
    logic signed [DATA_W+1:0] r_diff_p1;
    // S3: coefficients and outputs
    logic                    r_vld_p2, r_mode_p2, r_pd_p2, r_all_done;
    logic [PW-1:0]           r_rc_p2, r_pix_p2;
    logic [15:0]             r_mac_p2;
    logic [2:0]              r_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p0   <= 1'b0;
            r_mode_p0  <= 1'b0;
            r_last_p0  <= 1'b0;
            r_fin_p0   <= 1'b0;
            r_rc_p0    <= '0;
            r_pix_p0   <= '0;
            r_vld_p1   <= 1'b0;
            r_mode_p1  <= 1'b0;
            r_last_p1  <= 1'b0;
            r_fin_p1   <= 1'b0;
            r_rc_p1    <= '0;
            r_pix_p1   <= '0;
            r_vld_p2   <= 1'b0;
            r_mode_p2  <= 1'b0;
            r_pd_p2    <= 1'b0;
            r_rc_p2    <= '0;
            r_pix_p2   <= '0;
            r_mac_p2   <= '0;
            r_level    <= '0;
            r_all_done <= 1'b0;
        end else begin
            r_vld_p0 <= bus.i_mac_valid;
            if (bus.i_mac_valid) begin
                r_mode_p0 <= bus.i_mac_mode;
                r_rc_p0   <= bus.i_mac_row_column_pointer;
                r_pix_p0  <= bus.i_mac_pixel_pointer;
                r_last_p0 <= w_pass_end;
                r_fin_p0  <= w_pass_end && (r_state == ST_COL);
            end
            r_vld_p1 <= r_vld_p0;
            if (r_vld_p0) begin
                r_mode_p1 <= r_mode_p0;
                r_rc_p1   <= r_rc_p0;
                r_pix_p1  <= r_pix_p0;
                r_last_p1 <= r_last_p0;
                r_fin_p1  <= r_fin_p0;
            end
            r_vld_p2 <= r_vld_p1;
            r_pd_p2  <= r_vld_p1 && r_last_p1;
            if (r_vld_p1) begin
                r_mode_p2 <= r_mode_p1;
                r_rc_p2   <= r_rc_p1;
                r_pix_p2  <= r_pix_p1;
                r_mac_p2  <= {f_approx(r_sum_p1), f_detail(r_diff_p1)};
                if (r_fin_p1) begin
                    r_level <= r_level + 3'd1;
                    if ((r_level + 3'd1) == 3'(DECOMPOSITION_LEVEL)) r_all_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.i_mac_valid) begin
            r_a_p0 <= bus.i_mac[15:8];
            r_b_p0 <= bus.i_mac[7:0];
        end
        if (r_vld_p0) begin
            r_sum_p1  <= {1'b0, r_a_p0} + {1'b0, r_b_p0};
            r_diff_p1 <= $signed({2'b00, r_a_p0}) - $signed({2'b00, r_b_p0});
        end
    end

    assign bus.o_mac                    = r_mac_p2;
    assign bus.o_mac_valid              = r_vld_p2;
    assign bus.o_mac_mode               = r_mode_p2;
    assign bus.o_mac_row_column_pointer = r_rc_p2;
    assign bus.o_mac_pixel_pointer      = r_pix_p2;
    assign bus.o_pass_done              = r_pd_p2;
    assign bus.o_level                  = r_level;
    assign bus.o_all_done               = r_all_done;
    assign bus.o_seq_err                = r_seq_err;
endmodule
